// File: rtl/sprite_pkg.sv
// sprite_pkg: shared SAT layout, slot record, FSM encoding and line-hit helper
package sprite_pkg;
  localparam int NUM_SPRITES = 16;
  localparam int IDX_W = $clog2(NUM_SPRITES);
  localparam int SPRITE_SIZE = 16;
  localparam int COORD_W = 10;
  localparam int ATTR_W = 21;
  localparam int EN_BIT = 20;
  localparam int X_LSB = 10;
  localparam int Y_LSB = 0;
  localparam logic [COORD_W:0] SIZE_EXT = SPRITE_SIZE;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [IDX_W-1:0] id;
  } slot_t;
  function automatic logic line_hit(input logic [COORD_W-1:0] line, input logic [COORD_W-1:0] y);
    return ({1'b0, line} >= {1'b0, y}) && ({1'b0, line} < {1'b0, y} + SIZE_EXT);
  endfunction
endpackage

// File: rtl/sprite_priority_mux.sv
// sprite_priority_mux: registered lowest-index-wins compositor of renderer slots
module sprite_priority_mux #(
  parameter int NUM_SLOTS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SLOTS-1:0]   hit,
  input  logic [3*NUM_SLOTS-1:0] rgb,
  output logic [2:0]             pix_rgb,
  output logic                   pix_valid
);
  logic [2:0] pix_rgb_q, pix_rgb_d;
  logic pix_valid_q, pix_valid_d;
  always_comb begin
    pix_rgb_d = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) pix_rgb_d = hit[k] ? rgb[3*k +: 3] : pix_rgb_d;
    pix_valid_d = |hit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_rgb_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_rgb_q <= pix_rgb_d;
      pix_valid_q <= pix_valid_d;
    end
  end
  assign pix_rgb = pix_rgb_q;
  assign pix_valid = pix_valid_q;
endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: scans the SAT each hblank and commits up to NUM_SLOTS sprites for the next line
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         line_start,
  input  logic [COORD_W-1:0]           next_line,
  input  logic                         attr_we,
  input  logic [IDX_W-1:0]             attr_waddr,
  input  logic [ATTR_W-1:0]            attr_wdata,
  output logic                         busy,
  output logic                         line_ready,
  output logic                         overflow,
  output logic [NUM_SLOTS-1:0]         slot_valid,
  output logic [COORD_W*NUM_SLOTS-1:0] slot_x,
  output logic [COORD_W*NUM_SLOTS-1:0] slot_y,
  output logic [IDX_W*NUM_SLOTS-1:0]   slot_id,
  input  logic [NUM_SLOTS-1:0]         slot_hit,
  input  logic [3*NUM_SLOTS-1:0]       slot_rgb,
  output logic [2:0]                   pix_rgb,
  output logic                         pix_valid
);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, overflow_q, overflow_d, line_ready_q, line_ready_d;
  logic [COORD_W-1:0] line_q, line_d;
  logic [ATTR_W-1:0] sat_q [NUM_SPRITES];
  logic [ATTR_W-1:0] sat_d [NUM_SPRITES];
  slot_t shadow_q [NUM_SLOTS];
  slot_t shadow_d [NUM_SLOTS];
  slot_t slot_q [NUM_SLOTS];
  slot_t slot_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [ATTR_W-1:0] cur;
  logic hit;
  always_comb begin
    sat_d = sat_q;
    if (attr_we) sat_d[attr_waddr] = attr_wdata;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    line_d = line_q;
    shadow_d = shadow_q;
    slot_d = slot_q;
    slot_valid_d = slot_valid_q;
    overflow_d = overflow_q;
    line_ready_d = 1'b0;
    cur = sat_q[idx_q];
    hit = (state_q == SCAN) && cur[EN_BIT] && line_hit(line_q, cur[Y_LSB +: COORD_W]);
    if (line_start) begin
      state_d = SCAN;
      idx_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      line_d = next_line;
      for (int k = 0; k < NUM_SLOTS; k++) shadow_d[k] = '0;
    end else if (state_q == SCAN) begin
      for (int k = 0; k < NUM_SLOTS; k++)
        if (hit && cnt_q == CNT_W'(k)) shadow_d[k] = '{x: cur[X_LSB +: COORD_W], y: cur[Y_LSB +: COORD_W], id: idx_q};
      if (hit && cnt_q == CNT_W'(NUM_SLOTS)) ovf_d = 1'b1;
      else if (hit) cnt_d = cnt_q + 1'b1;
      idx_d = idx_q + 1'b1;
      state_d = (idx_q == IDX_W'(NUM_SPRITES - 1)) ? COMMIT : SCAN;
    end else if (state_q == COMMIT) begin
      slot_d = shadow_q;
      for (int k = 0; k < NUM_SLOTS; k++) slot_valid_d[k] = cnt_q > CNT_W'(k);
      overflow_d = ovf_q;
      line_ready_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      line_q <= '0;
      overflow_q <= 1'b0;
      line_ready_q <= 1'b0;
      slot_valid_q <= '0;
      for (int k = 0; k < NUM_SPRITES; k++) sat_q[k] <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        shadow_q[k] <= '0;
        slot_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      line_q <= line_d;
      overflow_q <= overflow_d;
      line_ready_q <= line_ready_d;
      slot_valid_q <= slot_valid_d;
      sat_q <= sat_d;
      shadow_q <= shadow_d;
      slot_q <= slot_d;
    end
  end
  always_comb begin
    busy = state_q != IDLE;
    line_ready = line_ready_q;
    overflow = overflow_q;
    slot_valid = slot_valid_q;
    slot_x = '0;
    slot_y = '0;
    slot_id = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_x[COORD_W*k +: COORD_W] = slot_q[k].x;
      slot_y[COORD_W*k +: COORD_W] = slot_q[k].y;
      slot_id[IDX_W*k +: IDX_W] = slot_q[k].id;
    end
  end
  sprite_priority_mux #(.NUM_SLOTS(NUM_SLOTS)) u_mux (
    .clk(clk),
    .reset(reset),
    .hit(slot_hit & slot_valid_q),
    .rgb(slot_rgb),
    .pix_rgb(pix_rgb),
    .pix_valid(pix_valid)
  );
endmodule
